// File: rtl/gen_mask_pkg.sv
// Shared types and helpers for the generate-time mask lane scanner.
package gen_mask_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } lane_state_e;

    function automatic int lane_iw(input int max_size);
        return (max_size > 1) ? $clog2(max_size) : 1;
    endfunction

endpackage

// File: rtl/gen_mask_lane_en.sv
// Elaboration-time lane enable vector; MASK bits beyond SIZE are never referenced.
module gen_mask_lane_en
    import gen_mask_pkg::*;
#(
    parameter int              MAX_SIZE = 8,
    parameter int              SIZE     = 5,
    parameter logic [SIZE-1:0] MASK     = 5'b10110,
    localparam int             IW       = lane_iw(MAX_SIZE)
) (
    output logic [MAX_SIZE-1:0] en,
    output logic [IW-1:0]       last_idx
);

    // The range test is the outer generate-if, so MASK[g] only exists where g < SIZE.
    for (genvar g = 0; g < MAX_SIZE; g++) begin : g_lane
        if (g < SIZE) begin : g_in
            assign en[g] = MASK[g];
        end else begin : g_out
            assign en[g] = 1'b0;
        end
    end

    always_comb begin
        last_idx = '0;
        for (int unsigned i = 0; i < MAX_SIZE; i++) begin
            if (en[i]) last_idx = IW'(i);
        end
    end

endmodule

// File: rtl/gen_mask_lane_scan.sv
// Walks the elaboration-time lane enables and streams each enabled lane index
// over a valid/ready handshake, pulsing done once the last lane is passed.
module gen_mask_lane_scan
    import gen_mask_pkg::*;
#(
    parameter int              MAX_SIZE = 8,
    parameter int              SIZE     = 5,
    parameter logic [SIZE-1:0] MASK     = 5'b10110,
    localparam int             IW       = lane_iw(MAX_SIZE),
    localparam int             CW       = $clog2(MAX_SIZE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          lane_valid,
    input  logic          lane_ready,
    output logic [IW-1:0] lane_idx,
    output logic          lane_last,
    output logic          done,
    output logic [CW-1:0] lane_count
);

    logic [MAX_SIZE-1:0] en;
    logic [IW-1:0]       last_idx;
    lane_state_e         state;
    logic [IW-1:0]       ptr;

    gen_mask_lane_en #(
        .MAX_SIZE (MAX_SIZE),
        .SIZE     (SIZE),
        .MASK     (MASK)
    ) u_lane_en (
        .en       (en),
        .last_idx (last_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            lane_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SCAN;
                        ptr        <= '0;
                        lane_count <= '0;
                    end
                end
                SCAN: begin
                    // Disabled lanes advance unconditionally; enabled ones wait for ready.
                    if (!en[ptr] || lane_ready) begin
                        if (en[ptr]) lane_count <= lane_count + CW'(1);
                        if (ptr == IW'(MAX_SIZE - 1)) state <= DONE;
                        else                          ptr   <= ptr + IW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        lane_valid = (state == SCAN) && en[ptr];
        lane_idx   = (state == SCAN) ? ptr : '0;
        lane_last  = lane_valid && (ptr == last_idx);
    end

endmodule

// File: tb/tb_gen_mask_lane_scan.sv
// Directed bench for gen_mask_lane_scan across default, all-masked and full-width configs.
module tb_gen_mask_lane_scan;

    logic clk;
    logic rst;
    logic start;
    logic ready_def;

    logic       busy_d, valid_d, last_d, done_d;
    logic [2:0] idx_d;
    logic [3:0] cnt_d;
    logic       busy_z, valid_z, last_z, done_z;
    logic [2:0] idx_z;
    logic [3:0] cnt_z;
    logic       busy_f, valid_f, last_f, done_f;
    logic [2:0] idx_f;
    logic [3:0] cnt_f;

    int tests;
    int fails;

    gen_mask_lane_scan #(.MAX_SIZE(8), .SIZE(5), .MASK(5'b10110)) u_def (
        .clk(clk), .rst(rst), .start(start), .busy(busy_d), .lane_valid(valid_d),
        .lane_ready(ready_def), .lane_idx(idx_d), .lane_last(last_d), .done(done_d),
        .lane_count(cnt_d)
    );

    gen_mask_lane_scan #(.MAX_SIZE(8), .SIZE(5), .MASK(5'b00000)) u_zero (
        .clk(clk), .rst(rst), .start(start), .busy(busy_z), .lane_valid(valid_z),
        .lane_ready(1'b1), .lane_idx(idx_z), .lane_last(last_z), .done(done_z),
        .lane_count(cnt_z)
    );

    gen_mask_lane_scan #(.MAX_SIZE(8), .SIZE(8), .MASK(8'hFF)) u_full (
        .clk(clk), .rst(rst), .start(start), .busy(busy_f), .lane_valid(valid_f),
        .lane_ready(1'b1), .lane_idx(idx_f), .lane_last(last_f), .done(done_f),
        .lane_count(cnt_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int pack(input logic b, input logic v, input logic l,
                                input logic d, input logic [2:0] i);
        return int'({b, v, l, d, i});
    endfunction

    // Unstalled scan on all three instances; cycle k counts from the start-accept edge.
    task automatic run_nominal(input string tag);
        int i_e;
        start     = 1'b1;
        ready_def = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            i_e = (k <= 8) ? k - 1 : 0;
            check($sformatf("%s def c%0d", tag, k), pack(busy_d, valid_d, last_d, done_d, idx_d),
                  pack(k <= 9, k == 2 || k == 3 || k == 5, k == 5, k == 9, 3'(i_e)));
            check($sformatf("%s zero c%0d", tag, k), pack(busy_z, valid_z, last_z, done_z, idx_z),
                  pack(k <= 9, 1'b0, 1'b0, k == 9, 3'(i_e)));
            check($sformatf("%s full c%0d", tag, k), pack(busy_f, valid_f, last_f, done_f, idx_f),
                  pack(k <= 9, k <= 8, k == 8, k == 9, 3'(i_e)));
            @(negedge clk);
        end
        check({tag, " def count"}, int'(cnt_d), 3);
        check({tag, " zero count"}, int'(cnt_z), 0);
        check({tag, " full count"}, int'(cnt_f), 8);
    endtask

    task automatic run_stall();
        int idx_tab[14] = '{0, 0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7, 0, 0};
        int want_idx[3] = '{1, 2, 4};
        int seen[$];
        start     = 1'b1;
        ready_def = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            check($sformatf("stall c%0d", k), pack(busy_d, valid_d, last_d, done_d, idx_d),
                  pack(k <= 12, k inside {2, 3, 4, 5, 6, 8}, k == 8, k == 12, 3'(idx_tab[k])));
            ready_def = !(k >= 3 && k <= 5);
            if (valid_d && ready_def) seen.push_back(int'(idx_d));
            @(negedge clk);
        end
        ready_def = 1'b1;
        check("stall count", int'(cnt_d), 3);
        check("stall handshakes", seen.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("stall hs%0d idx", i), (i < seen.size()) ? seen[i] : -1, want_idx[i]);
    endtask

    task automatic run_start_ignored();
        int n_done_d;
        int n_done_f;
        n_done_d  = 0;
        n_done_f  = 0;
        start     = 1'b1;
        ready_def = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (done_d) n_done_d++;
            if (done_f) n_done_f++;
            if (k == 9)  check("ign done c9", int'(done_d), 1);
            if (k == 10) check("ign busy c10", int'(busy_d), 0);
            start = (k == 3 || k == 9);
            @(negedge clk);
        end
        start = 1'b0;
        check("ign def done pulses", n_done_d, 1);
        check("ign full done pulses", n_done_f, 1);
        check("ign busy idle", int'(busy_d), 0);
    endtask

    task automatic run_reset_mid_scan();
        start     = 1'b1;
        ready_def = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst pre valid idx2", pack(busy_d, valid_d, last_d, done_d, idx_d),
              pack(1'b1, 1'b1, 1'b0, 1'b0, 3'd2));
        rst       = 1'b1;
        ready_def = 1'b0;
        @(negedge clk);
        check("rst def outputs", pack(busy_d, valid_d, last_d, done_d, idx_d), 0);
        check("rst def count", int'(cnt_d), 0);
        check("rst full outputs", pack(busy_f, valid_f, last_f, done_f, idx_f), 0);
        check("rst full count", int'(cnt_f), 0);
        rst       = 1'b0;
        ready_def = 1'b1;
        @(negedge clk);
        check("rst idle after", int'(busy_d), 0);
        run_nominal("rerun");
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        ready_def = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset def outputs", pack(busy_d, valid_d, last_d, done_d, idx_d), 0);
        check("reset def count", int'(cnt_d), 0);
        check("reset zero outputs", pack(busy_z, valid_z, last_z, done_z, idx_z), 0);
        check("reset full outputs", pack(busy_f, valid_f, last_f, done_f, idx_f), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle no start", int'(busy_d), 0);

        run_nominal("nom");
        repeat (3) @(negedge clk);
        check("idle count hold", int'(cnt_d), 3);
        check("idle full count hold", int'(cnt_f), 8);

        run_stall();
        repeat (2) @(negedge clk);
        run_start_ignored();
        repeat (2) @(negedge clk);
        run_reset_mid_scan();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gen_mask_lane_scan.md
Name: gen_mask_lane_scan

Overview:
- Transmit-side counterpart to the generate-time mask consumers in the generate/short-circuit regression group.
- A generate loop over MAX_SIZE lanes builds an enable vector from MASK. Every out-of-range bit is guarded by short-circuited (g < SIZE) && MASK[g].
- At run time the block walks the lanes and streams the index of each enabled lane over a valid/ready handshake.
- Serves as a regression block: it elaborates only if generate-if short-circuit evaluation is honoured, and it has real sequential behaviour to simulate.

Parameters:
- MAX_SIZE, 8, number of lanes the generate loop iterates over (≥2).
- SIZE, 5, number of valid MASK bits (1..MAX_SIZE).
- MASK, 5'b10110, per-lane enable, SIZE bits wide. Bits at g ≥ SIZE must never be evaluated.
- IW, $clog2(MAX_SIZE), lane index width (derived, not overridden).

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a scan; sampled only in IDLE.
- busy  out  1  high in SCAN and DONE.
- lane_valid  out  1  lane_idx is presenting an enabled lane.
- lane_ready  in  1  sink accepts lane_idx.
- lane_idx  out  IW  index of the presented lane.
- lane_last  out  1  presented lane is the highest enabled lane.
- done  out  1  one-cycle pulse at scan completion.
- lane_count  out  $clog2(MAX_SIZE+1)  handshakes completed in current/last scan.

Behaviour:
- Enable vector en[MAX_SIZE-1:0], fixed at elaboration:
  - For g < MAX_SIZE: en[g] = (g < SIZE) && MASK[g].
  - For g ≥ SIZE the right operand is never elaborated.
- LAST_IDX is the highest g with en[g]=1 (elaboration constant). It is meaningless when en==0.
- States: IDLE, SCAN, DONE.
- Reset (synchronous, any state, including mid-scan):
  - state=IDLE, ptr=0, lane_count=0.
  - busy=0, lane_valid=0, done=0, lane_idx=0, lane_last=0.
  - Any pending lane is dropped; no handshake occurs in the reset cycle.
- IDLE:
  - start=1 → SCAN next cycle, ptr=0, lane_count=0.
  - start=0 → stay in IDLE; lane_count holds its last value.
- SCAN examines lane ptr each cycle:
  - lane_valid = (state==SCAN) && en[ptr]. This is combinational from registered state/ptr, so there are no combinational paths from inputs.
  - lane_idx = ptr when in SCAN, else 0.
  - lane_last = lane_valid && (ptr==LAST_IDX).
  - en[ptr]=0: ptr advances after one cycle, no output.
  - en[ptr]=1: hold until lane_ready=1. On handshake, lane_count++ and ptr advances.
  - lane_ready while lane_valid=0 is ignored.
  - When lane ptr==MAX_SIZE-1 completes (skip or handshake) → DONE. ptr does not wrap.
- DONE:
  - done=1 for exactly one cycle, then → IDLE.
  - start in DONE is ignored.
- busy = (state != IDLE).
- start while busy is ignored; it is not queued.
- Scan length with no stall: SCAN occupies MAX_SIZE cycles. done is asserted MAX_SIZE+1 cycles after the start-accept cycle.
- en==0 (MASK=0): full walk with no valid, done pulses, lane_count=0.
- Back-pressure extends SCAN one cycle per stalled cycle. lane_idx/lane_last are stable while valid && !ready.

Decomposition:
- Package gen_mask_pkg:
  - state enum typedef (IDLE/SCAN/DONE).
  - function lane_iw(max_size) returning the index width.
- Sub-module gen_mask_lane_en:
  - Parameters MAX_SIZE/SIZE/MASK; output en[MAX_SIZE-1:0] and LAST_IDX.
  - Contains only the guarded generate loop, so the short-circuit construct is isolated and reusable.
- Top holds the FSM, ptr, counter and handshake.

Test Plan:
- Defaults (MAX_SIZE=8, SIZE=5, MASK=5'b10110), lane_ready tied 1, start pulse:
  - lane_valid with idx 1, 2, 4 in scan cycles 2, 3, 5; lane_last only with idx 4.
  - done 9 cycles after start accept; lane_count=3.
- Same config, lane_ready low 3 cycles while idx=2 presented:
  - idx 2 is held stable; done slips 3 cycles; lane_count=3; no duplicate idx.
- MASK=5'b00000:
  - Never lane_valid; done after 9 cycles; lane_count=0; lane_last never set.
- SIZE=MAX_SIZE=8, MASK=8'hFF, ready=1:
  - idx 0..7 consecutively; lane_last with idx 7; lane_count=8.
  - Elaboration is clean, proving the SIZE==MAX_SIZE guard.
- Start pulses during SCAN and DONE:
  - Ignored; exactly one done per accepted start; busy falls the cycle after done.
- rst asserted while idx=2 valid, then start again:
  - All outputs 0 the cycle after rst; lane_count=0.
  - The new scan restarts at idx 1 and completes normally.
